// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - streams bytes into a 256-byte program memory while holding the CPU in reset.
// Optional feature: define PROG_LOADER_CHECKSUM_EN for a mod-256 load checksum (exp_sum / sum / sum_err).
module prog_loader (
    input  logic       i_clock,
    input  logic       i_reset,
    input  logic       i_start,
    input  logic [7:0] i_base_addr,
    input  logic [7:0] i_length,
    input  logic       i_abort,
    input  logic       i_in_valid,
    input  logic [7:0] i_in_data,
`ifdef PROG_LOADER_CHECKSUM_EN
    input  logic [7:0] i_exp_sum,
    output logic [7:0] o_sum,
    output logic       o_sum_err,
`endif
    output logic       o_in_ready,
    output logic       o_mem_wren,
    output logic [7:0] o_mem_addr,
    output logic [7:0] o_mem_data,
    output logic       o_cpu_hold,
    output logic       o_done,
    output logic [7:0] o_remaining
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_next_state;
    logic [7:0] r_ptr;
    logic [7:0] r_remaining;
    logic       r_mem_wren;
    logic [7:0] r_mem_addr;
    logic [7:0] r_mem_data;
    logic       w_start_ok;
    logic       w_handshake;
    logic       w_hold_err;

    // abort outranks both start and a byte handshake in the same cycle
    assign w_start_ok  = i_start && !i_abort && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_handshake = (r_state == S_LOAD) && i_in_valid && !i_abort;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        if (i_abort) begin
            w_next_state = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (i_start) begin
                        w_next_state = (i_length == 8'd0) ? S_DONE : S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (i_in_valid) begin
                        w_next_state = S_WRITE;
                    end
                end
                S_WRITE: begin
                    w_next_state = (r_remaining == 8'd1) ? S_DONE : S_LOAD;
                end
                default: w_next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        o_in_ready = (r_state == S_LOAD);
        o_done     = (r_state == S_DONE);
        o_cpu_hold = (r_state != S_DONE) || w_hold_err;
    end

    // write strobe is the registered handshake, so it lives exactly in the WRITE cycle
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_ptr       <= 8'd0;
            r_remaining <= 8'd0;
            r_mem_wren  <= 1'b0;
            r_mem_addr  <= 8'd0;
            r_mem_data  <= 8'd0;
        end else begin
            r_mem_wren <= w_handshake;
            if (w_handshake) begin
                r_mem_addr <= r_ptr;
                r_mem_data <= i_in_data;
            end
            if (i_abort) begin
                r_remaining <= 8'd0;
            end else if (w_start_ok) begin
                r_ptr       <= i_base_addr;
                r_remaining <= i_length;
            end else if (r_state == S_WRITE) begin
                r_ptr       <= r_ptr + 8'd1;
                r_remaining <= r_remaining - 8'd1;
            end
        end
    end

    assign o_mem_wren  = r_mem_wren;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_data  = r_mem_data;
    assign o_remaining = r_remaining;

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] r_sum;
    logic [7:0] r_exp_sum;
    logic       r_sum_err;

    // a zero-length load enters DONE straight from start, so compare against the live input
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            r_sum     <= 8'd0;
            r_exp_sum <= 8'd0;
            r_sum_err <= 1'b0;
        end else begin
            if (w_start_ok) begin
                r_sum     <= 8'd0;
                r_exp_sum <= i_exp_sum;
                r_sum_err <= (i_length == 8'd0) && (i_exp_sum != 8'd0);
            end else if (w_handshake) begin
                r_sum <= r_sum + i_in_data;
            end
            if ((r_state == S_WRITE) && (w_next_state == S_DONE)) begin
                r_sum_err <= (r_sum != r_exp_sum);
            end
        end
    end

    assign o_sum      = r_sum;
    assign o_sum_err  = r_sum_err;
    assign w_hold_err = r_sum_err;
`else
    assign w_hold_err = 1'b0;
`endif

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader (directed vectors, optional PROG_LOADER_CHECKSUM_EN).
module tb_prog_loader;

    logic       clk = 1'b0;
    logic       rst;
    logic       i_start;
    logic [7:0] i_base_addr;
    logic [7:0] i_length;
    logic       i_abort;
    logic       i_in_valid;
    logic [7:0] i_in_data;
    logic       o_in_ready;
    logic       o_mem_wren;
    logic [7:0] o_mem_addr;
    logic [7:0] o_mem_data;
    logic       o_cpu_hold;
    logic       o_done;
    logic [7:0] o_remaining;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] i_exp_sum;
    logic [7:0] o_sum;
    logic       o_sum_err;
`endif

    prog_loader dut (
        .i_clock     (clk),
        .i_reset     (rst),
        .i_start     (i_start),
        .i_base_addr (i_base_addr),
        .i_length    (i_length),
        .i_abort     (i_abort),
        .i_in_valid  (i_in_valid),
        .i_in_data   (i_in_data),
`ifdef PROG_LOADER_CHECKSUM_EN
        .i_exp_sum   (i_exp_sum),
        .o_sum       (o_sum),
        .o_sum_err   (o_sum_err),
`endif
        .o_in_ready  (o_in_ready),
        .o_mem_wren  (o_mem_wren),
        .o_mem_addr  (o_mem_addr),
        .o_mem_data  (o_mem_data),
        .o_cpu_hold  (o_cpu_hold),
        .o_done      (o_done),
        .o_remaining (o_remaining)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] data;
        int         cyc;
    } wr_t;

    wr_t sb[$];
    int  errors   = 0;
    int  checks   = 0;
    int  cyc      = 0;
    int  wr_count = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // monitor: every write strobe must match the oldest expected write, in the expected cycle
    always @(negedge clk) begin
        if (o_mem_wren === 1'b1) begin
            wr_t e;
            wr_count++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write: got addr 0x%02h data 0x%02h expected no write",
                         o_mem_addr, o_mem_data);
            end else begin
                e = sb.pop_front();
                if (o_mem_addr !== e.addr || o_mem_data !== e.data || cyc != e.cyc) begin
                    errors++;
                    $display("FAIL write: got addr 0x%02h data 0x%02h cyc %0d expected addr 0x%02h data 0x%02h cyc %0d",
                             o_mem_addr, o_mem_data, cyc, e.addr, e.data, e.cyc);
                end
            end
        end
    end

    task automatic do_start(input logic [7:0] base, input logic [7:0] len, input logic [7:0] exp);
        i_start     = 1'b1;
        i_base_addr = base;
        i_length    = len;
`ifdef PROG_LOADER_CHECKSUM_EN
        i_exp_sum   = exp;
`else
        if (exp == 8'hxx) $display("unreachable");
`endif
        @(posedge clk);
        #1;
        i_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] data, input logic [7:0] exp_addr,
                             input logic [7:0] exp_rem, output int hs_cyc);
        bit got = 0;
        hs_cyc     = -1;
        i_in_valid = 1'b1;
        i_in_data  = data;
        for (int k = 0; k < 20 && !got; k++) begin
            @(negedge clk);
            if (o_in_ready === 1'b1) begin
                check8("remaining_at_handshake", o_remaining, exp_rem);
                @(posedge clk);
                #1;
                sb.push_back('{addr: exp_addr, data: data, cyc: cyc});
                hs_cyc = cyc;
                got    = 1;
            end
        end
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL handshake_timeout: got no in_ready expected handshake for 0x%02h", data);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check1({tag, "_cpu_hold"}, o_cpu_hold, 1'b1);
        check1({tag, "_mem_wren"}, o_mem_wren, 1'b0);
        check8({tag, "_mem_addr"}, o_mem_addr, 8'h00);
        check8({tag, "_mem_data"}, o_mem_data, 8'h00);
        check8({tag, "_remaining"}, o_remaining, 8'h00);
        check1({tag, "_in_ready"}, o_in_ready, 1'b0);
        check1({tag, "_done"}, o_done, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, c1;
        rst = 1'b1;
        i_start = 1'b0; i_base_addr = 8'h00; i_length = 8'h00; i_abort = 1'b0;
        i_in_valid = 1'b0; i_in_data = 8'h00;
`ifdef PROG_LOADER_CHECKSUM_EN
        i_exp_sum = 8'h00;
`endif
        #2;
        check_reset_values("reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check1("idle_in_ready", o_in_ready, 1'b0);
        check1("idle_done", o_done, 1'b0);

        // base 0x10, four bytes, continuous in_valid
        do_start(8'h10, 8'd4, 8'h8A);
        check8("load_remaining", o_remaining, 8'd4);
        check1("load_in_ready", o_in_ready, 1'b1);
        send_byte(8'hA1, 8'h10, 8'd4, c0);
        send_byte(8'hA2, 8'h11, 8'd3, c1);
        send_byte(8'hA3, 8'h12, 8'd2, c1);
        send_byte(8'hA4, 8'h13, 8'd1, c1);
        i_in_valid = 1'b0;
        check8("throughput_cycles", 8'(c1 - c0), 8'd6);
        @(negedge clk);
        check1("write_cpu_hold", o_cpu_hold, 1'b1);
        check1("write_done", o_done, 1'b0);
        @(posedge clk); #1;
        check1("done_after_load", o_done, 1'b1);
        check1("cpu_hold_after_load", o_cpu_hold, 1'b0);
        check8("remaining_after_load", o_remaining, 8'd0);

        // pointer wrap from 0xFE
        do_start(8'hFE, 8'd3, 8'h06);
        check1("restart_cpu_hold", o_cpu_hold, 1'b1);
        send_byte(8'h01, 8'hFE, 8'd3, c1);
        send_byte(8'h02, 8'hFF, 8'd2, c1);
        send_byte(8'h03, 8'h00, 8'd1, c1);
        i_in_valid = 1'b0;
        @(posedge clk); #1;
        check1("wrap_done", o_done, 1'b1);

        // zero-length load
        do_start(8'h20, 8'd0, 8'h00);
        check1("len0_done", o_done, 1'b1);
        check1("len0_cpu_hold", o_cpu_hold, 1'b0);
        check1("len0_in_ready", o_in_ready, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        check1("len0_no_wren", o_mem_wren, 1'b0);

        // abort together with a valid byte after the 2nd handshake
        do_start(8'h40, 8'd5, 8'h00);
        send_byte(8'h11, 8'h40, 8'd5, c1);
        send_byte(8'h22, 8'h41, 8'd4, c1);
        i_in_data = 8'h33;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (o_in_ready === 1'b1) break;
        end
        i_abort = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
        check1("abort_in_ready", o_in_ready, 1'b0);
        check1("abort_cpu_hold", o_cpu_hold, 1'b1);
        check8("abort_remaining", o_remaining, 8'd0);
        check1("abort_done", o_done, 1'b0);
        repeat (3) @(negedge clk);
        check1("abort_stays_idle", o_in_ready, 1'b0);
        i_in_valid = 1'b0;

        // abort during WRITE keeps the strobed write
        do_start(8'h50, 8'd3, 8'h00);
        send_byte(8'h55, 8'h50, 8'd3, c1);
        i_in_valid = 1'b0;
        i_abort    = 1'b1;
        @(posedge clk); #1;
        i_abort = 1'b0;
        check1("abort_write_in_ready", o_in_ready, 1'b0);
        check8("abort_write_remaining", o_remaining, 8'd0);
        repeat (2) @(posedge clk);
        #1;

        // start is ignored in LOAD and WRITE
        do_start(8'h60, 8'd2, 8'hDD);
        do_start(8'h00, 8'd9, 8'h00);
        check8("start_in_load_ignored", o_remaining, 8'd2);
        send_byte(8'h66, 8'h60, 8'd2, c1);
        i_in_valid = 1'b0;
        do_start(8'h00, 8'd9, 8'h00);
        check8("start_in_write_ignored", o_remaining, 8'd1);
        send_byte(8'h77, 8'h61, 8'd1, c1);
        i_in_valid = 1'b0;
        @(posedge clk); #1;
        check1("ignored_start_done", o_done, 1'b1);

        // reset mid-WRITE acts before the next edge
        do_start(8'h70, 8'd3, 8'h00);
        send_byte(8'h88, 8'h70, 8'd3, c1);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        check_reset_values("async_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        i_in_valid = 1'b1;
        repeat (4) @(negedge clk);
        check1("post_reset_in_ready", o_in_ready, 1'b0);
        check1("post_reset_cpu_hold", o_cpu_hold, 1'b1);
        i_in_valid = 1'b0;

`ifdef PROG_LOADER_CHECKSUM_EN
        do_start(8'h00, 8'd2, 8'h10);
        send_byte(8'h80, 8'h00, 8'd2, c1);
        send_byte(8'h90, 8'h01, 8'd1, c1);
        i_in_valid = 1'b0;
        @(posedge clk); #1;
        check1("sum_ok_done", o_done, 1'b1);
        check1("sum_ok_err", o_sum_err, 1'b0);
        check1("sum_ok_cpu_hold", o_cpu_hold, 1'b0);
        check8("sum_value", o_sum, 8'h10);
        do_start(8'h00, 8'd2, 8'h11);
        send_byte(8'h80, 8'h00, 8'd2, c1);
        send_byte(8'h90, 8'h01, 8'd1, c1);
        i_in_valid = 1'b0;
        @(posedge clk); #1;
        check1("sum_bad_done", o_done, 1'b1);
        check1("sum_bad_err", o_sum_err, 1'b1);
        check1("sum_bad_cpu_hold", o_cpu_hold, 1'b1);
        do_start(8'h00, 8'd0, 8'h00);
        check1("sum_err_cleared", o_sum_err, 1'b0);
        check1("sum_err_cleared_hold", o_cpu_hold, 1'b0);
`endif

        repeat (3) @(posedge clk);
        #1;
        check8("scoreboard_empty", 8'(sb.size()), 8'd0);
`ifdef PROG_LOADER_CHECKSUM_EN
        check8("write_count", 8'(wr_count), 8'd17);
`else
        check8("write_count", 8'(wr_count), 8'd13);
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
